// File: rtl/ulx3s_timer.sv
// rtl/ulx3s_timer.sv - memory-mapped machine timer responder on the Ibex data bus
module ulx3s_timer #(
    parameter logic [31:0] BaseAddr = 32'h00010000,
    parameter logic [31:0] AddrMask = 32'h000000FF,
    parameter int unsigned Prescale = 25
) (
    input  logic        clk_sys,
    input  logic        rst_sys_n,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        irq_timer_o
);

    localparam logic [15:0] PrescaleMax = 16'(Prescale - 1);

    localparam logic [5:0] OffMtimeLo = 6'h00;
    localparam logic [5:0] OffMtimeHi = 6'h01;
    localparam logic [5:0] OffCmpLo   = 6'h02;
    localparam logic [5:0] OffCmpHi   = 6'h03;
    localparam logic [5:0] OffCtrl    = 6'h04;
    localparam logic [5:0] OffStatus  = 6'h05;

    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        en_q;
    logic [15:0] cnt_q;
    logic        rvalid_q, err_q, irq_q;
    logic [31:0] rdata_q;

    logic        hit, reg_ok, access_ok, wr_en, tick, time_ge;
    logic [5:0]  word;
    logic [31:0] rd_val;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  be);
        logic [31:0] r;
        r = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                r[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return r;
    endfunction

    assign gnt_o     = req_i;
    assign hit       = (addr_i & ~AddrMask) == BaseAddr;
    assign word      = addr_i[7:2];
    assign time_ge   = mtime_q >= mtimecmp_q;
    assign access_ok = hit && reg_ok;
    assign wr_en     = req_i && we_i && access_ok;
    assign tick      = en_q && (cnt_q == PrescaleMax);

    always_comb begin
        reg_ok = 1'b1;
        rd_val = '0;
        case (word)
            OffMtimeLo: rd_val = mtime_q[31:0];
            OffMtimeHi: rd_val = mtime_q[63:32];
            OffCmpLo:   rd_val = mtimecmp_q[31:0];
            OffCmpHi:   rd_val = mtimecmp_q[63:32];
            OffCtrl:    rd_val = {31'b0, en_q};
            OffStatus:  rd_val = {31'b0, time_ge};
            default:    reg_ok = 1'b0;
        endcase
    end

    // A software write to either mtime half wins over the tick, dropping that increment.
    always_comb begin
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        if (wr_en && word == OffMtimeLo) begin
            mtime_d[31:0] = byte_merge(mtime_q[31:0], wdata_i, be_i);
        end else if (wr_en && word == OffMtimeHi) begin
            mtime_d[63:32] = byte_merge(mtime_q[63:32], wdata_i, be_i);
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end
        if (wr_en && word == OffCmpLo) begin
            mtimecmp_d[31:0] = byte_merge(mtimecmp_q[31:0], wdata_i, be_i);
        end
        if (wr_en && word == OffCmpHi) begin
            mtimecmp_d[63:32] = byte_merge(mtimecmp_q[63:32], wdata_i, be_i);
        end
    end

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            en_q       <= 1'b0;
            cnt_q      <= '0;
            rvalid_q   <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            irq_q      <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            if (wr_en && word == OffCtrl && be_i[0]) begin
                en_q <= wdata_i[0];
            end
            if (!en_q || tick) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 16'd1;
            end
            rvalid_q <= req_i;
            err_q    <= req_i && !access_ok;
            rdata_q  <= (req_i && access_ok && !we_i) ? rd_val : '0;
            irq_q    <= time_ge;
        end
    end

    assign rvalid_o    = rvalid_q;
    assign err_o       = err_q;
    assign rdata_o     = rdata_q;
    assign irq_timer_o = irq_q;

endmodule

// File: doc/ulx3s_timer.md
Name: ulx3s_timer

Overview:
- Memory-mapped machine timer that answers Ibex data-bus requests (req/gnt/rvalid), i.e. a bus responder alongside the SRAM.
- Holds a 64-bit mtime counter advanced by a prescaled tick, a 64-bit mtimecmp, a control register and a status register.
- Drives the core's irq_timer_i input.
- Sits behind the top-level data-side address decode and returns rdata/err one cycle after grant, with the same timing as the SRAM responder.

Parameters:
- BaseAddr, 32'h00010000, byte base address of the register window.
- AddrMask, 32'h000000FF, window size mask; window is 256 bytes.
- Prescale, 25, clk_sys cycles per mtime increment; legal range 1..65535.

Ports:
- clk_sys  in  1  system clock.
- rst_sys_n  in  1  reset: asynchronous, active-low.
- req_i  in  1  data request from the decoded Ibex data port.
- we_i  in  1  write enable, qualified by req_i.
- be_i  in  4  byte enables for writes.
- addr_i  in  32  byte address; bits [1:0] ignored.
- wdata_i  in  32  write data.
- gnt_o  out  1  grant.
- rvalid_o  out  1  response valid.
- rdata_o  out  32  read data, valid with rvalid_o.
- err_o  out  1  error response, valid with rvalid_o.
- irq_timer_o  out  1  timer interrupt to the core.

Behaviour:
- Reset (asynchronous, rst_sys_n low):
  - rvalid_o=0, err_o=0, rdata_o=0, irq_timer_o=0.
  - mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, CTRL=0, prescale count=0.
  - A response pending at reset assertion is dropped and never issued.
- Handshake:
  - gnt_o = req_i combinationally; the block is always ready.
  - Request accepted on the rising edge where req_i=1.
  - rvalid_o=1 exactly one cycle after acceptance, for reads and writes; back-to-back requests give back-to-back rvalid.
- Address decode:
  - hit = (addr_i & ~AddrMask) == BaseAddr.
  - A request with no hit is still granted and answered with err_o=1, rdata_o=0. The top decode must not route such requests here.
- Register map (offset = addr_i[7:2]*4):
  - 0x00 MTIME_LO, RW.
  - 0x04 MTIME_HI, RW.
  - 0x08 MTIMECMP_LO, RW.
  - 0x0C MTIMECMP_HI, RW.
  - 0x10 CTRL, RW: bit0 EN, other bits read 0, writes ignored.
  - 0x14 STATUS, RO: bit0 = mtime >= mtimecmp; writes ignored, no error.
  - Any other offset: err_o=1 and rdata_o=0 on rvalid; no state change.
- Writes:
  - Applied at the accept edge, byte-wise per be_i; be_i=0 is a legal no-op.
  - rdata_o=0 on a write response.
- Reads: rdata_o is the register value at the accept edge, before any increment in that cycle.
- Tick:
  - When EN=1, the prescale count runs 0..Prescale-1.
  - A tick fires when the count equals Prescale-1; the count then wraps to 0.
  - With Prescale=1 a tick fires every cycle.
  - When EN=0, the count is held at 0 and mtime is frozen.
- Increment:
  - On a tick, mtime <= mtime+1 as a full 64-bit add.
  - Carry propagates from LO to HI; 64'hFFFF_FFFF_FFFF_FFFF wraps to 0.
- Simultaneous write and tick:
  - A write to MTIME_LO or MTIME_HI in a tick cycle takes priority.
  - Written bytes take wdata_i, unwritten bytes keep the old value, and that tick's increment is dropped.
  - The prescale count still wraps.
- IRQ:
  - irq_timer_o registered: value at cycle n+1 = (mtime >= mtimecmp), unsigned 64-bit compare of register values at cycle n.
  - Level signal; software clears it by raising mtimecmp or lowering mtime.
- No multi-cycle state beyond the single response stage; no backpressure on rvalid.

Test Plan:
- Reset/idle: release reset, no requests, EN=0 for 100 cycles -> irq_timer_o=0, reads of MTIME_LO/HI return 0, MTIMECMP_LO/HI return 32'hFFFFFFFF, each read rvalid exactly 1 cycle after gnt.
- Count rate: Prescale=25, write CTRL=1, wait 250 cycles, read MTIME_LO -> 10 (±1 depending on write/read alignment); write CTRL=0, wait 100 cycles -> value unchanged.
- Carry/wrap: Prescale=1, write MTIME_HI=0, MTIME_LO=32'hFFFFFFFE, EN=1 -> after 2 ticks MTIME_HI=1, MTIME_LO=0. Separately, load all-ones then one tick -> both halves 0.
- IRQ: Prescale=1, mtime=0, MTIMECMP_HI=0, MTIMECMP_LO=20, EN=1 -> irq_timer_o rises the cycle after mtime reaches 20 and STATUS=1. Write MTIMECMP_LO=1000 -> irq_timer_o low one cycle after the write.
- Byte enables and write-vs-tick: Prescale=1, EN=1, write MTIME_LO=32'hAABBCCDD with be_i=4'b0101 when low bytes are 0x..0010 -> result bytes {old[31:24],BB,old[15:8],DD}, no +1 that cycle. Write STATUS -> no change, err_o=0.
- Errors/reset: read offset 0x18 -> err_o=1, rdata_o=0; read address BaseAddr+0x100 -> err_o=1. Assert rst_sys_n the cycle after an accepted read -> no rvalid_o, all registers back at reset values.
